// File: rtl/centroid_div_sched_if.sv
// Handshake bundle between the centroid scheduler and the shared divider.
// The scheduler is master: it issues operands and a start pulse, the divider answers with qv.
interface centroid_div_sched_if #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 20
);
    logic                  div_start;
    logic [DIVIDEND_W-1:0] div_dividend;
    logic [DIVISOR_W-1:0]  div_divisor;
    logic [DIVIDEND_W-1:0] div_quotient;
    logic                  div_qv;

    modport master (
        output div_start, div_dividend, div_divisor,
        input  div_quotient, div_qv
    );

    modport slave (
        input  div_start, div_dividend, div_divisor,
        output div_quotient, div_qv
    );
endinterface

// File: rtl/centroid_div_sched.sv
// Time-shares one divider for centroid x = m_01/m_00 and y = m_10/m_00.
// x/y publish together on xy_valid; empty, overrun and timeout are reported as pulses.
module centroid_div_sched #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 20,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_eof,
    input  logic [DIVIDEND_W-1:0] i_m_01,
    input  logic [DIVIDEND_W-1:0] i_m_10,
    input  logic [DIVISOR_W-1:0]  i_m_00,
    centroid_div_sched_if.master  div,
    output logic [DIVIDEND_W-1:0] o_x,
    output logic [DIVIDEND_W-1:0] o_y,
    output logic                  o_xy_valid,
    output logic                  o_empty_frame,
    output logic                  o_overrun,
    output logic                  o_div_timeout,
    output logic                  o_busy
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_X,
        S_WAIT_X,
        S_ISSUE_Y,
        S_WAIT_Y
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic [DIVIDEND_W-1:0] r_snap_m10;
    logic [DIVIDEND_W-1:0] r_dividend;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [DIVIDEND_W-1:0] r_qx;
    logic [DIVIDEND_W-1:0] r_x;
    logic [DIVIDEND_W-1:0] r_y;
    logic                  r_xy_valid;
    logic                  r_empty;
    logic                  r_overrun;
    logic                  r_tmo;

    logic w_idle;
    logic w_issue;
    logic w_wait;
    logic w_eof_ok;
    logic w_to;

    assign w_idle   = (r_state == S_IDLE);
    assign w_issue  = (r_state == S_ISSUE_X) || (r_state == S_ISSUE_Y);
    assign w_wait   = (r_state == S_WAIT_X) || (r_state == S_WAIT_Y);
    assign w_eof_ok = i_eof && (i_m_00 != '0);
    assign w_to     = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_eof_ok) w_next = S_ISSUE_X;
            S_ISSUE_X: w_next = S_WAIT_X;
            S_WAIT_X: begin
                if (div.div_qv)  w_next = S_ISSUE_Y;
                else if (w_to)   w_next = S_IDLE;
            end
            S_ISSUE_Y: w_next = S_WAIT_Y;
            S_WAIT_Y: begin
                if (div.div_qv || w_to) w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_snap_m10 <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_qx       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_xy_valid <= 1'b0;
            r_empty    <= 1'b0;
            r_overrun  <= 1'b0;
            r_tmo      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_xy_valid <= (r_state == S_WAIT_Y) && div.div_qv;
            r_empty    <= w_idle && i_eof && (i_m_00 == '0);
            r_overrun  <= !w_idle && i_eof;
            r_tmo      <= w_wait && !div.div_qv && w_to;
            // Operand registers double as the m_01/m_00 snapshot.
            if (w_idle && w_eof_ok) begin
                r_dividend <= i_m_01;
                r_divisor  <= i_m_00;
                r_snap_m10 <= i_m_10;
            end
            if (w_issue)
                r_cnt <= '0;
            else if (w_wait && !div.div_qv && !w_to)
                r_cnt <= r_cnt + CW'(1);
            if ((r_state == S_WAIT_X) && div.div_qv) begin
                r_qx       <= div.div_quotient;
                r_dividend <= r_snap_m10;
            end
            if ((r_state == S_WAIT_Y) && div.div_qv) begin
                r_x <= r_qx;
                r_y <= div.div_quotient;
            end
        end
    end

    assign div.div_start    = w_issue;
    assign div.div_dividend = r_dividend;
    assign div.div_divisor  = r_divisor;

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_xy_valid    = r_xy_valid;
    assign o_empty_frame = r_empty;
    assign o_overrun     = r_overrun;
    assign o_div_timeout = r_tmo;
    assign o_busy        = !w_idle;
endmodule

// File: tb/tb_centroid_div_sched.sv
// Directed bench for centroid_div_sched with a fixed-latency divider model.
// Covers nominal, empty frame, overrun, timeout, spurious qv and mid-run reset.
module tb_centroid_div_sched;
    localparam int L = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        eof = 1'b0;
    logic [31:0] m01 = '0;
    logic [31:0] m10 = '0;
    logic [19:0] m00 = '0;
    logic [31:0] x, y;
    logic        xy_valid, empty_frame, overrun, div_timeout, busy;

    centroid_div_sched_if #(.DIVIDEND_W(32), .DIVISOR_W(20)) dif ();

    centroid_div_sched #(.DIVIDEND_W(32), .DIVISOR_W(20), .TIMEOUT(64)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_eof(eof),
        .i_m_01(m01),
        .i_m_10(m10),
        .i_m_00(m00),
        .div(dif.master),
        .o_x(x),
        .o_y(y),
        .o_xy_valid(xy_valid),
        .o_empty_frame(empty_frame),
        .o_overrun(overrun),
        .o_div_timeout(div_timeout),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Divider model: qv is sampled L edges after the edge that sampled start.
    logic        pend = 1'b0;
    int          dcnt = 0;
    logic [31:0] dq = '0;
    logic        noans = 1'b0;
    logic        spur = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else if (dif.div_start && !noans) begin
            pend <= 1'b1;
            dcnt <= L - 1;
            dq   <= dif.div_dividend / 32'(dif.div_divisor);
        end else if (pend) begin
            if (dcnt == 0) pend <= 1'b0;
            else dcnt <= dcnt - 1;
        end
    end

    assign dif.div_qv = (pend && dcnt == 0) || spur;
    assign dif.div_quotient = (pend && dcnt == 0) ? dq :
                              (spur ? 32'hDEAD_BEEF : 32'h0);

    int cyc = 0;
    always @(posedge clk) cyc++;

    int          n_start = 0, n_xy = 0, n_empty = 0, n_ovr = 0, n_tmo = 0, n_busy = 0;
    int          eof_cyc = 0, xy_cyc = 0;
    logic [31:0] op_a = '0, op_b = '0;

    always @(negedge clk) begin
        if (dif.div_start) begin
            op_a = op_b;
            op_b = dif.div_dividend;
            n_start++;
        end
        if (xy_valid) begin
            n_xy++;
            xy_cyc = cyc;
        end
        if (eof)         eof_cyc = cyc;
        if (empty_frame) n_empty++;
        if (overrun)     n_ovr++;
        if (div_timeout) n_tmo++;
        if (busy)        n_busy++;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic frame(input logic [31:0] a, input logic [31:0] b, input logic [19:0] c);
        @(posedge clk); #1;
        eof = 1'b1; m01 = a; m10 = b; m00 = c;
        @(posedge clk); #1;
        eof = 1'b0;
    endtask

    task automatic wait_xy(input int n0, input int maxc);
        int k;
        k = 0;
        while (n_xy == n0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        if (n_xy == n0) chk("wait_xy_expired", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    int s0, x0, e0, o0, t0, b0;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", dif.div_start, 0);
        chk("rst_dividend", dif.div_dividend, 0);
        rst_n = 1'b1;

        // 1: nominal frame
        s0 = n_start; x0 = n_xy;
        frame(6400, 4800, 64);
        wait_xy(x0, 100);
        chk("t1_x", x, 100);
        chk("t1_y", y, 75);
        chk("t1_starts", n_start - s0, 2);
        chk("t1_op_x", op_a, 6400);
        chk("t1_op_y", op_b, 4800);
        chk("t1_nxy", n_xy - x0, 1);
        chk("t1_latency", xy_cyc - eof_cyc, 13);
        chk("t1_busy", busy, 0);
        chk("t1_hold_dividend", dif.div_dividend, 4800);

        // 2: empty frame
        s0 = n_start; e0 = n_empty; b0 = n_busy;
        frame(123, 456, 0);
        repeat (5) @(negedge clk);
        chk("t2_starts", n_start - s0, 0);
        chk("t2_empty", n_empty - e0, 1);
        chk("t2_busy", n_busy - b0, 0);
        chk("t2_x", x, 100);
        chk("t2_y", y, 75);

        // 3: overrun
        s0 = n_start; x0 = n_xy; o0 = n_ovr;
        frame(1000, 2000, 10);
        repeat (3) @(posedge clk);
        frame(9, 9, 3);
        wait_xy(x0, 100);
        repeat (10) @(negedge clk);
        chk("t3_overrun", n_ovr - o0, 1);
        chk("t3_starts", n_start - s0, 2);
        chk("t3_nxy", n_xy - x0, 1);
        chk("t3_x", x, 100);
        chk("t3_y", y, 200);

        // 4: divider never answers
        noans = 1'b1;
        s0 = n_start; x0 = n_xy; t0 = n_tmo;
        frame(50, 60, 5);
        for (int k = 0; k < 300 && n_tmo == t0; k++) @(negedge clk);
        chk("t4_timeout", n_tmo - t0, 1);
        chk("t4_busy", busy, 0);
        chk("t4_starts", n_start - s0, 1);
        chk("t4_nxy", n_xy - x0, 0);
        chk("t4_x", x, 100);
        chk("t4_y", y, 200);
        noans = 1'b0;
        x0 = n_xy;
        frame(300, 600, 3);
        wait_xy(x0, 100);
        chk("t4_next_x", x, 100);
        chk("t4_next_y", y, 200);
        chk("t4_next_latency", xy_cyc - eof_cyc, 13);

        // 5: spurious qv in IDLE and in ISSUE_X
        s0 = n_start; x0 = n_xy;
        @(posedge clk); #1;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        eof = 1'b1; m01 = 770; m10 = 1540; m00 = 7;
        @(posedge clk); #1;
        eof = 1'b0;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        wait_xy(x0, 100);
        chk("t5_x", x, 110);
        chk("t5_y", y, 220);
        chk("t5_starts", n_start - s0, 2);
        chk("t5_latency", xy_cyc - eof_cyc, 13);

        // 6: reset during WAIT_Y
        x0 = n_xy;
        frame(900, 450, 9);
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_x", x, 0);
        chk("t6_async_y", y, 0);
        chk("t6_async_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_no_xy", n_xy - x0, 0);
        frame(1200, 600, 12);
        wait_xy(x0, 100);
        chk("t6_x", x, 100);
        chk("t6_y", y, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
